// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: fetch PC, synchronous imem read issue, one-entry skid
// buffer for the word in flight during a stall, and the IF/ID pipeline register.
module if_fetch_unit #(
  parameter int unsigned           NB_PC      = 32,
  parameter int unsigned           NB_INSTR   = 32,
  parameter logic [NB_PC-1:0]      RESET_PC   = '0,
  parameter logic [NB_INSTR-1:0]   HALT_INSTR = '1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [NB_PC-1:0]    i_next_pc,
  input  logic                i_redirect,
  input  logic                i_stall,
  output logic [NB_PC-1:0]    o_pc_plus4,
  output logic [NB_PC-1:0]    o_imem_addr,
  output logic                o_imem_rd,
  input  logic [NB_INSTR-1:0] i_imem_data,
  output logic [NB_INSTR-1:0] o_instr,
  output logic [NB_PC-1:0]    o_pc,
  output logic                o_valid,
  output logic                o_halted
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HALT
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [NB_PC-1:0]    pc;
  logic                inf;
  logic [NB_PC-1:0]    inf_pc;
  logic                sk_v;
  logic [NB_INSTR-1:0] sk_instr;
  logic [NB_PC-1:0]    sk_pc;
  logic                fetching;
  logic                halt_load;
  logic                issue;

  assign fetching = (state == ST_FETCH);

  // The skid entry, when present, is always the next word to reach IF/ID.
  always_comb begin
    halt_load = 1'b0;
    if (fetching && !i_redirect && !i_stall) begin
      if (sk_v)
        halt_load = (sk_instr == HALT_INSTR);
      else if (inf)
        halt_load = (i_imem_data == HALT_INSTR);
    end
  end

  assign issue       = fetching & ~i_stall & ~sk_v & ~i_redirect & ~halt_load;
  assign o_imem_rd   = issue;
  assign o_imem_addr = pc;
  assign o_pc_plus4  = pc + NB_PC'(4);
  assign o_halted    = (state == ST_HALT);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (i_start)   state_nxt = ST_FETCH;
      ST_FETCH: if (halt_load) state_nxt = ST_HALT;
      default:  state_nxt = state;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc       <= RESET_PC;
      inf      <= 1'b0;
      inf_pc   <= '0;
      sk_v     <= 1'b0;
      sk_instr <= '0;
      sk_pc    <= '0;
      o_valid  <= 1'b0;
      o_instr  <= '0;
      o_pc     <= '0;
    end else if (i_redirect) begin
      pc      <= i_next_pc;
      inf     <= 1'b0;
      sk_v    <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      inf <= issue;
      if (issue) begin
        pc     <= i_next_pc;
        inf_pc <= pc;
      end
      // A halt load never issues, so the in-flight flag clears by itself;
      // a halt taken from the skid empties it on the same edge.
      if (i_stall) begin
        if (inf) begin
          sk_v     <= 1'b1;
          sk_instr <= i_imem_data;
          sk_pc    <= inf_pc;
        end
      end else if (sk_v) begin
        o_valid <= 1'b1;
        o_instr <= sk_instr;
        o_pc    <= sk_pc;
        sk_v    <= 1'b0;
      end else if (inf) begin
        o_valid <= 1'b1;
        o_instr <= i_imem_data;
        o_pc    <= inf_pc;
      end else begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: queue-based reference model of the fetch stream plus
// directed scenario checks, with a synchronous instruction memory model.
module tb_if_fetch_unit;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] tgt = '0;
  logic [31:0] next_pc;
  logic [31:0] pc_plus4;
  logic [31:0] imem_addr;
  logic        imem_rd;
  logic [31:0] imem_data = '0;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        valid;
  logic        halted;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  logic [31:0] halt_addr = 32'h1;

  if_fetch_unit #(
    .NB_PC(32),
    .NB_INSTR(32),
    .RESET_PC(32'h0),
    .HALT_INSTR(32'hFFFF_FFFF)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .i_next_pc(next_pc),
    .i_redirect(redir),
    .i_stall(stall),
    .o_pc_plus4(pc_plus4),
    .o_imem_addr(imem_addr),
    .o_imem_rd(imem_rd),
    .i_imem_data(imem_data),
    .o_instr(instr),
    .o_pc(pc_out),
    .o_valid(valid),
    .o_halted(halted)
  );

  always #5 clk = ~clk;

  // Bench plays the next-PC mux.
  assign next_pc = redir ? tgt : pc_plus4;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == halt_addr) return HALT;
    return (a ^ 32'h1357_9BDF) & 32'hFFFF_FFFE;
  endfunction

  always @(posedge clk) imem_data <= imem_rd ? mem(imem_addr) : $urandom;

  // Reference model: fetch stream as queues of PCs.
  bit          m_run, m_halt, m_v, m_rd, m_halt_now;
  logic [31:0] m_pc, m_opc, m_oinstr;
  logic [31:0] m_fly[$];
  logic [31:0] m_skid[$];
  logic [130:0] exp_pk;
  logic [130:0] obs_pk;
  localparam logic [130:0] RESET_PK = {1'b0, 32'h0, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0};

  assign obs_pk = {imem_rd, imem_addr, pc_plus4, valid, pc_out, instr, halted};

  task automatic model_comb();
    bit          have = 0;
    logic [31:0] nxt = '0;
    if (m_skid.size() != 0) begin have = 1; nxt = m_skid[0]; end
    else if (m_fly.size() != 0) begin have = 1; nxt = m_fly[0]; end
    m_halt_now = m_run && !m_halt && !redir && !stall && have && (mem(nxt) == HALT);
    m_rd = m_run && !m_halt && !stall && !redir && (m_skid.size() == 0) && !m_halt_now;
    exp_pk = {m_rd, m_pc, m_pc + 32'd4, m_v, m_opc, m_oinstr, m_halt};
  endtask

  task automatic deliver(input logic [31:0] p);
    m_v = 1; m_opc = p; m_oinstr = mem(p);
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_run = 0; m_halt = 0; m_v = 0; m_pc = '0; m_opc = '0; m_oinstr = '0;
      m_fly.delete(); m_skid.delete();
    end else begin
      if (redir) begin
        m_pc = tgt; m_fly.delete(); m_skid.delete(); m_v = 0;
      end else begin
        if (stall) begin
          if (m_fly.size() != 0) m_skid.push_back(m_fly.pop_front());
        end else if (m_skid.size() != 0) deliver(m_skid.pop_front());
        else if (m_fly.size() != 0) deliver(m_fly.pop_front());
        else m_v = 0;
        if (m_halt_now) begin m_halt = 1; m_fly.delete(); m_skid.delete(); end
        if (m_rd) begin m_fly.push_back(m_pc); m_pc = m_pc + 32'd4; end
      end
      if (start && !m_run) m_run = 1;
    end
  endtask

  task automatic drive(input bit st, input bit sl, input bit rd, input logic [31:0] t, input bit rn);
    @(negedge clk);
    start = st; stall = sl; redir = rd; tgt = t; rst_n = rn;
    #1;
    model_comb();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
  endtask

  task automatic restart();
    drive(0, 0, 0, '0, 0); advance();
    drive(0, 0, 0, '0, 0); advance();
    drive(1, 0, 0, '0, 1); advance();
  endtask

  task automatic test_reset();
    drive(0, 0, 0, '0, 0); advance();
    drive(0, 0, 0, '0, 0); advance();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, '0, 1);
      n_cmp++;
      if (obs_pk !== RESET_PK) begin
        n_fail++;
        $display("FAIL reset_values c%0d: got %h want %h", i, obs_pk, RESET_PK);
      end
      n_cmp++;
      if (obs_pk !== exp_pk) begin
        n_fail++;
        $display("FAIL reset_model c%0d: got %h want %h", i, obs_pk, exp_pk);
      end
      advance();
    end
  endtask

  task automatic test_start();
    restart();
    for (int i = 1; i <= 8; i++) begin
      drive(0, 0, 0, '0, 1);
      n_cmp++;
      if (obs_pk !== exp_pk) begin
        n_fail++;
        $display("FAIL start_model c%0d: got %h want %h", i, obs_pk, exp_pk);
      end
      if (i <= 3) begin
        n_cmp++;
        if (imem_rd !== 1'b1 || imem_addr !== 32'(4 * (i - 1))) begin
          n_fail++;
          $display("FAIL start_read c%0d: got rd=%b addr=%h want rd=1 addr=%h", i, imem_rd, imem_addr, 4 * (i - 1));
        end
        n_cmp++;
        if (valid !== (i == 3) || (i == 3 && pc_out !== 32'h0)) begin
          n_fail++;
          $display("FAIL start_latency c%0d: got v=%b pc=%h want v=%b pc=0", i, valid, pc_out, i == 3);
        end
      end
      advance();
    end
  endtask

  task automatic test_stall_skid();
    logic [31:0] seen[$];
    logic [31:0] last = 32'h8;
    restart();
    for (int i = 1; i <= 14; i++) begin
      bit sl = (i >= 5 && i <= 7);
      drive(0, sl, 0, '0, 1);
      n_cmp++;
      if (obs_pk !== exp_pk) begin
        n_fail++;
        $display("FAIL stall_model c%0d: got %h want %h", i, obs_pk, exp_pk);
      end
      if (sl) begin
        n_cmp++;
        if (valid !== 1'b1 || pc_out !== 32'h8) begin
          n_fail++;
          $display("FAIL stall_hold c%0d: got v=%b pc=%h want v=1 pc=8", i, valid, pc_out);
        end
      end
      if (i >= 8 && valid === 1'b1 && pc_out !== last) begin
        seen.push_back(pc_out);
        last = pc_out;
      end
      advance();
    end
    n_cmp++;
    if (seen.size() < 2) begin
      n_fail++;
      $display("FAIL stall_release_count: got %0d pcs want >=2", seen.size());
    end
    foreach (seen[k]) begin
      n_cmp++;
      if (seen[k] !== 32'(12 + 4 * k)) begin
        n_fail++;
        $display("FAIL stall_sequence #%0d: got %h want %h", k, seen[k], 12 + 4 * k);
      end
    end
  endtask

  task automatic test_redirect();
    bit bad = 0;
    restart();
    for (int i = 1; i <= 14; i++) begin
      drive(0, 0, i == 6, 32'h100, 1);
      n_cmp++;
      if (obs_pk !== exp_pk) begin
        n_fail++;
        $display("FAIL redirect_model c%0d: got %h want %h", i, obs_pk, exp_pk);
      end
      if (valid === 1'b1 && pc_out === 32'h10) bad = 1;
      if (i == 7 || i == 8) begin
        n_cmp++;
        if (valid !== 1'b0) begin
          n_fail++;
          $display("FAIL redirect_bubble c%0d: got v=%b want v=0", i, valid);
        end
      end
      if (i == 9) begin
        n_cmp++;
        if (valid !== 1'b1 || pc_out !== 32'h100 || instr !== mem(32'h100)) begin
          n_fail++;
          $display("FAIL redirect_target: got v=%b pc=%h ins=%h want v=1 pc=100 ins=%h", valid, pc_out, instr, mem(32'h100));
        end
      end
      advance();
    end
    n_cmp++;
    if (bad) begin
      n_fail++;
      $display("FAIL redirect_squash: got pc 10 valid want never valid");
    end
  endtask

  task automatic test_redirect_stall();
    bit bad = 0;
    restart();
    for (int i = 1; i <= 12; i++) begin
      drive(0, i == 5 || i == 6, i == 6, 32'h200, 1);
      n_cmp++;
      if (obs_pk !== exp_pk) begin
        n_fail++;
        $display("FAIL rdstall_model c%0d: got %h want %h", i, obs_pk, exp_pk);
      end
      if (valid === 1'b1 && pc_out === 32'hC) bad = 1;
      if (i == 7) begin
        n_cmp++;
        if (valid !== 1'b0 || imem_rd !== 1'b1 || imem_addr !== 32'h200) begin
          n_fail++;
          $display("FAIL rdstall_restart: got v=%b rd=%b addr=%h want v=0 rd=1 addr=200", valid, imem_rd, imem_addr);
        end
      end
      if (i == 9) begin
        n_cmp++;
        if (valid !== 1'b1 || pc_out !== 32'h200) begin
          n_fail++;
          $display("FAIL rdstall_target: got v=%b pc=%h want v=1 pc=200", valid, pc_out);
        end
      end
      advance();
    end
    n_cmp++;
    if (bad) begin
      n_fail++;
      $display("FAIL rdstall_skid_drop: got pc C valid want never valid");
    end
  endtask

  task automatic test_halt();
    int unsigned cnt = 0;
    halt_addr = 32'h20;
    restart();
    for (int i = 1; i <= 16; i++) begin
      drive(i == 13, 0, 0, '0, 1);
      n_cmp++;
      if (obs_pk !== exp_pk) begin
        n_fail++;
        $display("FAIL halt_model c%0d: got %h want %h", i, obs_pk, exp_pk);
      end
      if (valid === 1'b1 && pc_out === 32'h20) begin
        cnt++;
        n_cmp++;
        if (instr !== HALT) begin
          n_fail++;
          $display("FAIL halt_instr: got %h want %h", instr, HALT);
        end
      end
      if (i == 10 || i >= 11) begin
        n_cmp++;
        if (imem_rd !== 1'b0 || halted !== (i >= 11)) begin
          n_fail++;
          $display("FAIL halt_state c%0d: got rd=%b h=%b want rd=0 h=%b", i, imem_rd, halted, i >= 11);
        end
      end
      if (i >= 12) begin
        n_cmp++;
        if (valid !== 1'b0) begin
          n_fail++;
          $display("FAIL halt_drop c%0d: got v=%b want v=0", i, valid);
        end
      end
      advance();
    end
    n_cmp++;
    if (cnt != 1) begin
      n_fail++;
      $display("FAIL halt_once: got %0d want 1", cnt);
    end
    drive(0, 0, 0, '0, 0); advance();
    drive(0, 0, 0, '0, 1);
    n_cmp++;
    if (obs_pk !== RESET_PK) begin
      n_fail++;
      $display("FAIL halt_reset: got %h want %h", obs_pk, RESET_PK);
    end
    advance();
    halt_addr = 32'h1;
  endtask

  task automatic test_wrap_reset();
    restart();
    for (int i = 1; i <= 12; i++) begin
      drive(0, 0, i == 2, 32'hFFFF_FFF8, i != 10);
      n_cmp++;
      if (obs_pk !== exp_pk) begin
        n_fail++;
        $display("FAIL wrap_model c%0d: got %h want %h", i, obs_pk, exp_pk);
      end
      if (i == 4) begin
        n_cmp++;
        if (imem_addr !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
          n_fail++;
          $display("FAIL wrap_plus4: got addr=%h pc4=%h want addr=fffffffc pc4=0", imem_addr, pc_plus4);
        end
      end
      if (i == 7) begin
        n_cmp++;
        if (valid !== 1'b1 || pc_out !== 32'h0) begin
          n_fail++;
          $display("FAIL wrap_deliver: got v=%b pc=%h want v=1 pc=0", valid, pc_out);
        end
      end
      if (i == 11) begin
        n_cmp++;
        if (obs_pk !== RESET_PK) begin
          n_fail++;
          $display("FAIL midrun_reset: got %h want %h", obs_pk, RESET_PK);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    halt_addr = ($urandom_range(1) == 0) ? 32'h1 : {20'h0, 4'($urandom_range(15)), 8'h0} + 32'h40;
    restart();
    for (int i = 1; i <= 400; i++) begin
      bit rn = ($urandom_range(99) != 0) && !(m_halt && $urandom_range(9) == 0);
      drive($urandom_range(7) == 0, $urandom_range(3) == 0, $urandom_range(11) == 0,
            {22'h0, 8'($urandom_range(255)), 2'b00}, rn);
      n_cmp++;
      if (obs_pk !== exp_pk) begin
        n_fail++;
        $display("FAIL random_model c%0d: got %h want %h", i, obs_pk, exp_pk);
      end
      advance();
    end
    halt_addr = 32'h1;
  endtask

  initial begin
    test_reset();
    test_start();
    test_stall_skid();
    test_redirect();
    test_redirect_stall();
    test_halt();
    test_wrap_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the pipelined core: holds the fetch PC, issues reads to the synchronous instruction memory, and loads the IF/ID pipeline register. It sits directly upstream of the next-PC 2:1 multiplexer. It supplies that mux's sequential input (`o_pc_plus4`) and consumes the mux output (`i_next_pc`) together with the mux select (`i_redirect`). A one-entry skid buffer absorbs the memory word still in flight when the hazard unit stalls the stage.

## Interface
- `NB_PC`, 32, PC / address width.
- `NB_INSTR`, 32, instruction width.
- `RESET_PC`, 0, fetch PC after reset.
- `HALT_INSTR`, 32'hFFFF_FFFF, encoding that stops fetch once delivered to ID.

Ports:
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst_n`  in  1  synchronous, active-low reset.
- `i_start`  in  1  leave IDLE and begin fetching (from debug unit).
- `i_next_pc`  in  NB_PC  next-PC mux output.
- `i_redirect`  in  1  next-PC mux select; 1 means a taken branch or jump from EX.
- `i_stall`  in  1  hazard unit; hold IF/ID and PC.
- `o_pc_plus4`  out  NB_PC  fetch PC + 4, drives mux input `i_a`.
- `o_imem_addr`  out  NB_PC  instruction-memory address (= fetch PC).
- `o_imem_rd`  out  1  read strobe; data returns on `i_imem_data` the next cycle.
- `i_imem_data`  in  NB_INSTR  read data, valid the cycle after `o_imem_rd`.
- `o_instr`  out  NB_INSTR  IF/ID instruction.
- `o_pc`  out  NB_PC  IF/ID PC of `o_instr`.
- `o_valid`  out  1  IF/ID holds a live instruction.
- `o_halted`  out  1  state is HALT.

## Operation
- **States:** IDLE, FETCH, HALT.
  - IDLE → FETCH on `i_start`.
  - FETCH → HALT when IF/ID loads `HALT_INSTR`.
  - HALT → IDLE only on reset.
- **Registers:** fetch PC `pc`; in-flight flag `inf` and its PC `inf_pc`; skid entry (`sk_v`, `sk_instr`, `sk_pc`); IF/ID (`o_valid`, `o_instr`, `o_pc`).
- **Read issue:** `o_imem_rd` = (state==FETCH) & ~`i_stall` & ~`sk_v` & ~`i_redirect` & ~halt-load-this-cycle.
  - `o_imem_addr` = `pc`.
  - On issue: `pc` ← `i_next_pc`, `inf` ← 1, `inf_pc` ← `pc`.
  - Otherwise `inf` ← 0 and `pc` holds.
- **Return, not stalled:** IF/ID ← {1, `i_imem_data`, `inf_pc`}.
- **Return, stalled:** skid ← {1, `i_imem_data`, `inf_pc`}; IF/ID holds.
- **Stall release with `sk_v`=1:** IF/ID ← skid, `sk_v` ← 0. No read is issued that cycle, because `sk_v` was 1.
- **No return, not stalled, skid empty:** `o_valid` ← 0 (bubble).
- **Redirect (`i_redirect`=1), highest priority:**
  - `pc` ← `i_next_pc`.
  - `inf`, `sk_v`, `o_valid` ← 0.
  - The returning word is discarded.
  - Applies even if `i_stall`=1.
- **Halt:** when `HALT_INSTR` loads into IF/ID, the state becomes HALT. No further reads; any in-flight word and the skid entry are discarded. The halt instruction stays valid until the first non-stalled cycle, then `o_valid` ← 0.
- **Arithmetic:** `o_pc_plus4` = `pc` + 4, modulo 2^NB_PC; 32'hFFFF_FFFC wraps to 0.

## Timing
- **Reset values:**
  - `pc` = `RESET_PC`, state = IDLE.
  - `o_imem_rd` = 0, `o_imem_addr` = `RESET_PC`, `o_pc_plus4` = `RESET_PC`+4.
  - `o_valid` = 0, `o_instr` = 0, `o_pc` = 0, `o_halted` = 0.
  - `inf` = `sk_v` = 0.
- **Latency:** `i_start` sampled at edge T → first read issued in cycle T+1 → `o_valid`=1 with `o_pc`=`RESET_PC` in cycle T+3.
- **Throughput:** one instruction per cycle, unstalled.
- **Stall timing:** stall asserted in cycle S blocks the read in S. The read issued in S−1 returns in S and is captured in the skid. After release, IF/ID loads the skid entry first, then reads resume with no lost or duplicated PC.
- **Redirect timing:** redirect in cycle R → target read issued in R+1 → target instruction valid in R+3. Exactly two bubbles.
- **Mid-operation reset:** `i_rst_n`=0 at any edge restores all reset values. In-flight data is ignored.

## Test plan
- **Reset/start:** hold `i_rst_n`=0 for 2 cycles, then pulse `i_start`. Required: reads at 0, 4, 8; `o_pc` sequence 0, 4, 8 with `o_valid`=1 from the third cycle after `i_start`.
- **Stall/skid:** steady fetch, then `i_stall` for 3 cycles while IF/ID holds PC 8. Required: IF/ID holds PC 8; after release, `o_pc` is 12, then 16. No duplicate and no gap.
- **Redirect:** `i_redirect`=1 with `i_next_pc`=0x100 while PC 0x10 is in flight. Required: 0x10 is never valid; next valid `o_pc`=0x100 exactly 3 cycles later.
- **Redirect during stall:** `i_stall`=1 and `i_redirect`=1 with the skid full. Required: skid dropped, `o_valid`=0; fetch restarts at the target.
- **Halt:** memory returns 0xFFFF_FFFF at PC 0x20. Required: it appears once with `o_pc`=0x20; `o_halted`=1; `o_imem_rd` stays 0; `o_valid` drops; only reset returns to IDLE.
- **Wrap and mid-run reset:** `pc`=0xFFFF_FFFC gives `o_pc_plus4`=0. Asserting reset mid-run restores every output to its reset value on the next edge.
